// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a programmable access latency.
module dmem_responder #(
    parameter logic [63:0] ADDR_BASE   = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned DATA_W = 64;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $fatal(1, "dmem_responder: LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                write_q, write_d;
    logic [63:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [7:0]          wmask_q, wmask_d;

    logic                access;

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) << 3;

    logic [DATA_W-1:0]   mem_q [DEPTH_WORDS];
    logic [63:0]         offset;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic                mem_we_d;
    logic [DATA_W-1:0]   mem_word_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        access  = 1'b0;
        // Unsigned wrap makes addresses below ADDR_BASE land far out of range.
        offset     = addr_q - ADDR_BASE;
        in_range   = offset < SPAN;
        idx        = offset[IDX_W+2:3];
        mem_we_d   = 1'b0;
        mem_word_d = mem_q[idx];

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = S_RESP;
                    rdata_d = '0;
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (write_q) begin
                        mem_we_d = 1'b1;
                        for (int b = 0; b < 8; b++) begin
                            if (wmask_q[b]) mem_word_d[8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end else begin
                        rdata_d = mem_q[idx];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Captured request fields are pure data and need no reset.
    always_ff @(posedge clk) begin
        write_q <= write_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
    end

    // A reset during WAIT forces IDLE, so a pending store never reaches this write.
    always_ff @(posedge clk) begin
        if (access && mem_we_d) mem_q[idx] <= mem_word_d;
    end

    assign req_ready  = rst_n && (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a word-level memory model.
module tb_dmem_responder;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 3;
    localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr  = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;

    dmem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic        chk_data;
        int unsigned acc_cyc;
        int unsigned stall;
    } exp_t;

    exp_t        q[$];
    logic [63:0] model_mem [longint unsigned];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for the DUT (cycle %0d)", name, cyc);
    endtask

    // Reference behaviour: word-granular memory, byte-masked stores, range check on the byte offset.
    function automatic exp_t model(input logic wr, input logic [63:0] addr,
                                   input logic [63:0] wdata, input logic [7:0] wmask);
        exp_t e;
        logic [63:0] off;
        longint unsigned w;
        logic [63:0] word;
        e.rdata = '0; e.err = 1'b0; e.chk_data = 1'b1; e.acc_cyc = 0; e.stall = 0;
        off = addr - BASE;
        if (off >= SPAN) begin
            e.err = 1'b1;
        end else begin
            w = off / 8;
            if (wr) begin
                word = model_mem.exists(w) ? model_mem[w] : 64'h0;
                for (int b = 0; b < 8; b++)
                    if (wmask[b]) word[8*b +: 8] = wdata[8*b +: 8];
                if (model_mem.exists(w) || wmask == 8'hFF) model_mem[w] = word;
            end else if (model_mem.exists(w)) begin
                e.rdata = model_mem[w];
            end else begin
                e.chk_data = 1'b0;
            end
        end
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Issue one request (called at a negedge); use_k forces a directed expected load value.
    task automatic issue(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wmask, input int unsigned stall,
                         input logic use_k, input logic [63:0] k);
        exp_t e;
        int budget = 0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
        while (!req_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            fail_now("req_accept");
            req_valid = 1'b0;
            return;
        end
        e = model(wr, addr, wdata, wmask);
        if (use_k) e.rdata = k;
        e.acc_cyc = cyc + 1;
        e.stall = stall;
        q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom}; req_wmask = 8'($urandom);
        @(negedge clk);
    endtask

    // Monitor: owns resp_ready, checks latency, stability under backpressure and post-handshake idle.
    initial begin
        bit seen = 0;
        bit idle_chk = 0;
        int unsigned stall_left = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                resp_ready = 1'b0;
                seen = 0;
                idle_chk = 0;
            end else begin
                if (idle_chk) begin
                    chk("idle_resp_valid", 64'(resp_valid), 64'd0);
                    chk("idle_req_ready", 64'(req_ready), 64'd1);
                    chk("idle_rdata", resp_rdata, 64'd0);
                    chk("idle_err", 64'(resp_err), 64'd0);
                    idle_chk = 0;
                end
                if (resp_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_resp_valid", 64'(resp_valid), 64'd0);
                        resp_ready = 1'b1;
                    end else begin
                        if (!seen) begin
                            chk("latency_cycle", 64'(cyc), 64'(q[0].acc_cyc + LAT));
                            seen = 1;
                            stall_left = q[0].stall;
                        end
                        if (q[0].chk_data) chk("resp_rdata", resp_rdata, q[0].rdata);
                        chk("resp_err", 64'(resp_err), 64'(q[0].err));
                        chk("req_ready_in_resp", 64'(req_ready), 64'd0);
                        if (stall_left > 0) begin
                            stall_left--;
                            resp_ready = 1'b0;
                        end else begin
                            resp_ready = 1'b1;
                            void'(q.pop_front());
                            seen = 0;
                            idle_chk = 1;
                        end
                    end
                end else begin
                    resp_ready = 1'($urandom);
                    if (q.size() > 0 && cyc > q[0].acc_cyc)
                        chk("req_ready_in_wait", 64'(req_ready), 64'd0);
                end
            end
        end
    end

    initial begin
        logic [63:0] pool [12];
        logic [63:0] oor  [5];
        logic [63:0] a;
        int budget;
        pool = '{0, 1, 2, 3, 4, 5, 6, 7, 100, 511, 1022, 1023};
        oor  = '{BASE - 64'd8, BASE + SPAN, BASE + SPAN + 64'h1000, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8};

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);

        // Give every pool word a known value.
        foreach (pool[i])
            issue(1'b1, BASE + pool[i] * 8, {$urandom, $urandom}, 8'hFF, 0, 1'b0, 64'h0);

        // Basic store/load round trip.
        issue(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 0, 1'b0, 64'h0);
        issue(1'b0, 64'h8000_0008, 64'h0, 8'h00, 0, 1'b1, 64'h1122_3344_5566_7788);

        // Partial-mask store on top of a full one.
        issue(1'b1, BASE + 64'd16, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 0, 1'b0, 64'h0);
        issue(1'b1, BASE + 64'd16, 64'h0, 8'h0F, 1, 1'b0, 64'h0);
        issue(1'b0, BASE + 64'd16, 64'h0, 8'h00, 0, 1'b1, 64'hAAAA_AAAA_0000_0000);

        // Zero-mask store is a no-op.
        issue(1'b1, BASE + 64'd16, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 1'b0, 64'h0);
        issue(1'b0, BASE + 64'd16, 64'h0, 8'h00, 0, 1'b1, 64'hAAAA_AAAA_0000_0000);

        // Long backpressure while a load response is held.
        issue(1'b0, 64'h8000_0008, 64'h0, 8'h00, 5, 1'b1, 64'h1122_3344_5566_7788);

        // Out-of-range accesses; an out-of-range store must not touch the edge words.
        issue(1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 0, 1'b0, 64'h0);
        issue(1'b0, BASE + SPAN, 64'h0, 8'h00, 2, 1'b0, 64'h0);
        issue(1'b1, BASE + SPAN, 64'h5555_5555_5555_5555, 8'hFF, 0, 1'b0, 64'h0);
        issue(1'b1, BASE - 64'd8, 64'h5555_5555_5555_5555, 8'hFF, 0, 1'b0, 64'h0);
        issue(1'b0, BASE, 64'h0, 8'h00, 0, 1'b0, 64'h0);
        issue(1'b0, BASE + SPAN - 64'd8, 64'h0, 8'h00, 0, 1'b0, 64'h0);

        // Store to word 4 aborted by reset while in WAIT.
        issue(1'b1, BASE + 64'd32, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 1'b0, 64'h0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = BASE + 64'd32;
        req_wdata = 64'hDEAD; req_wmask = 8'hFF;
        budget = 0;
        while (!req_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) fail_now("reset_test_accept");
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_rdata", resp_rdata, 64'd0);
        chk("midrst_err", 64'(resp_err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, BASE + 64'd32, 64'h0, 8'h00, 0, 1'b1, 64'h0123_4567_89AB_CDEF);

        // Randomized mix of loads, stores and out-of-range requests.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 7)
                a = BASE + pool[$urandom_range(0, 11)] * 8 + 64'($urandom_range(0, 7));
            else
                a = oor[$urandom_range(0, 4)] + 64'($urandom_range(0, 7));
            issue(1'($urandom), a, {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                  $urandom_range(0, 3), 1'b0, 64'h0);
        end

        budget = 0;
        while (q.size() != 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() != 0) fail_now("drain_responses");
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the core's data-memory request interface. It services load and store requests issued by the core-side initiator over a valid/ready request channel and a valid/ready response channel. The backing store is a 64-bit-word internal array with a programmable access latency. At most one transaction is outstanding. The block replaces direct combinational pmem access when multi-cycle memory timing is exercised.

Parameters:
ADDR_BASE, 64'h0000000080000000, byte address mapped to word 0 of the array
DEPTH_WORDS, 1024, number of 64-bit words in the array (power of two)
LATENCY, 2, cycles from request acceptance to response-valid (legal range 1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  initiator has a request
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  64  byte address; bits [2:0] ignored
req_wdata  in  64  store data, byte lanes aligned to the 64-bit word
req_wmask  in  8  store byte enables; bit i enables wdata[8i+7:8i]
resp_valid  out  1  response available
resp_ready  in  1  initiator accepts the response
resp_rdata  out  64  load data; 0 for stores and for errors
resp_err  out  1  address outside [ADDR_BASE, ADDR_BASE + 8*DEPTH_WORDS)

Behaviour:
- Reset (async assert, sync release): state IDLE, req_ready=0 while rst_n=0, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Array contents are not reset.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0; counter counts down.
  - RESP: req_ready=0; resp_valid=1.
- IDLE -> WAIT on req_valid. Latch write, address, wdata, and wmask. Load counter with LATENCY-1.
- WAIT: when counter==0, perform the access in that cycle and go to RESP. Otherwise decrement.
  - resp_valid rises exactly LATENCY cycles after the accepting edge.
- Access:
  - Word index = (addr - ADDR_BASE) >> 3, computed in 64-bit unsigned arithmetic.
  - In range, load: resp_rdata = array[index].
  - In range, store: each enabled byte is written; resp_rdata=0. wmask=0 is a legal no-op.
  - Out of range (including addr < ADDR_BASE via unsigned wrap): resp_err=1, resp_rdata=0, no array write.
- RESP: resp_valid, resp_rdata, and resp_err are held stable until resp_valid && resp_ready, then go to IDLE.
  - resp_valid drops on the next cycle; resp_rdata and resp_err return to 0.
  - req_ready reasserts in the same cycle as the return to IDLE. There is no same-cycle acceptance during RESP.
- Request inputs are sampled only at the accepting edge. Later changes have no effect.
- A load issued after a store response observes the stored data (read-after-write).
- Reset mid-operation: an accepted store still in WAIT is discarded and the array is unchanged. A store already performed (RESP state) is kept.
- Counter is 4 bits. LATENCY outside 1..15 is a compile-time error; an elaboration-time check with $fatal is required.

Optional Feature:
DMEM_DPI_EN
- Defined: the internal array is removed. The access cycle calls DPI pmem_read(addr, rdata, 1) for loads and pmem_write(addr, wdata, wmask, 1) for stores. The full 64-bit address is passed and the range check is disabled, so resp_err is constant 0. Timing and handshake are unchanged.
- Undefined: the internal array and range check are used as described above. No DPI imports are compiled.

Test Plan:
1. Store addr 0x80000008, wdata 0x1122334455667788, wmask 0xFF; then load 0x80000008 -> resp_rdata 0x1122334455667788, resp_err 0.
2. Store wdata 0xAAAAAAAAAAAAAAAA, wmask 0xFF; then store wdata 0, wmask 0x0F to the same word; then load -> 0xAAAAAAAA00000000.
3. LATENCY=3: req_valid accepted at edge N -> resp_valid high from edge N+3. req_ready stays 0 from N+1 until the handshake completes.
4. Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready=0. Raise resp_ready -> IDLE next cycle, resp_valid=0, req_ready=1.
5. Load 0x7FFFFFF8, and load ADDR_BASE+8*DEPTH_WORDS -> resp_err=1, rdata=0. An out-of-range store leaves word 0 and the last word unchanged.
6. Store 0xDEAD to word 4, then pull rst_n low during WAIT -> outputs 0 immediately. After release, load word 4 -> prior contents, not 0xDEAD.
